instr_prefetch_buffer: RTL and testbench

//  Instruction fetch front end directly upstream of the decode/execute datapath (alu, condcheck, mux).

---
 rtl/instr_prefetch_buffer.sv | 162 ++++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: fetch PC, imem req/ack, {instr, pc} FIFO.
// Flush redirects fetch and drops queued and in-flight words.
module instr_prefetch_buffer #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [WIDTH-1:0]           imem_addr,
    input  logic                       imem_ack,
    input  logic [WIDTH-1:0]           imem_rdata,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           flush_pc,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_instr,
    output logic [WIDTH-1:0]           out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_fetch_pc;
    logic             r_imem_req;
    logic [WIDTH-1:0] r_imem_addr;
    logic [WIDTH-1:0] r_mem_instr [DEPTH];
    logic [WIDTH-1:0] r_mem_pc    [DEPTH];
    logic [AW-1:0]    r_rptr;
    logic [AW-1:0]    r_wptr;
    logic [CW-1:0]    r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_instr;
    logic [WIDTH-1:0] r_out_pc;

    logic [WIDTH-1:0] w_flush_pc;
    logic [WIDTH-1:0] w_addr_inc;
    logic             w_pop;
    logic             w_push;
    logic [CW-1:0]    w_avail;
    logic [CW-1:0]    w_count_nx;
    logic [AW-1:0]    w_rptr_nx;

    assign w_flush_pc = {flush_pc[WIDTH-1:2], 2'b00};
    assign w_addr_inc = r_imem_addr + WIDTH'(4);
    assign w_pop      = r_out_valid & out_ready & ~flush;
    assign w_push     = (r_state == S_REQ) & imem_ack & ~flush;
    // entries left once this cycle's pop is taken
    assign w_avail    = r_count - CW'(w_pop);
    assign w_count_nx = flush ? '0 : w_avail + CW'(w_push);
    assign w_rptr_nx  = flush ? '0 : r_rptr + AW'(w_pop);

    // Fetch FSM: request only when the returning word has a free slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
            r_fetch_pc  <= RESET_PC;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_fetch_pc <= w_flush_pc;
                    end else if (w_avail < CW'(DEPTH)) begin
                        r_state     <= S_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_fetch_pc;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        if (flush) begin
                            r_fetch_pc <= w_flush_pc;
                            r_state    <= S_IDLE;
                            r_imem_req <= 1'b0;
                        end else begin
                            r_fetch_pc <= w_addr_inc;
                            if (w_count_nx < CW'(DEPTH)) begin
                                r_imem_addr <= w_addr_inc;
                            end else begin
                                r_state    <= S_IDLE;
                                r_imem_req <= 1'b0;
                            end
                        end
                    end else if (flush) begin
                        r_fetch_pc <= w_flush_pc;
                        r_state    <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (flush) begin
                        r_fetch_pc <= w_flush_pc;
                    end
                    if (imem_ack) begin
                        r_state    <= S_IDLE;
                        r_imem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage write on accepted words
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wptr] <= imem_rdata;
            r_mem_pc[r_wptr]    <= r_imem_addr;
        end
    end

    // FIFO pointers, count and registered fall-through head
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rptr      <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
        end else begin
            r_rptr      <= w_rptr_nx;
            r_count     <= w_count_nx;
            r_out_valid <= (w_count_nx != '0);
            if (flush) begin
                r_wptr <= '0;
            end else if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (!flush) begin
                if (w_avail != '0) begin
                    r_out_instr <= r_mem_instr[w_rptr_nx];
                    r_out_pc    <= r_mem_pc[w_rptr_nx];
                end else if (w_push) begin
                    r_out_instr <= imem_rdata;
                    r_out_pc    <= r_imem_addr;
                end
            end
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_imem_addr;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign count     = r_count;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer.
// Memory returns addr ^ K so every instruction word is predictable.
module tb_instr_prefetch_buffer;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    instr_prefetch_buffer #(
        .WIDTH(32),
        .DEPTH(4),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .flush(flush),
        .flush_pc(flush_pc),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_ready(out_ready),
        .count(count)
    );

    assign imem_rdata = imem_addr ^ K;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        imem_ack  = 1'b0;
        flush     = 1'b0;
        flush_pc  = 32'h0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);

        // 1: streaming, one word per cycle
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        reset     = 1'b0;
        tick();
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_valid0", 32'(out_valid), 32'd0);
        for (int k = 2; k <= 7; k++) begin
            tick();
            chk("t1_addr", imem_addr, 32'(4 * (k - 1)));
            chk("t1_pc", out_pc, 32'(4 * (k - 2)));
            chk("t1_instr", out_instr, 32'(4 * (k - 2)) ^ K);
            chk("t1_count", 32'(count), 32'd1);
        end

        // 2: stalled consumer fills exactly DEPTH words
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b0;
        reset     = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("t2_addr3", imem_addr, 32'hC);
        tick();
        chk("t2_count4", 32'(count), 32'd4);
        chk("t2_req_off", 32'(imem_req), 32'd0);
        chk("t2_head0", out_pc, 32'h0);
        tick();
        chk("t2_idle_req", 32'(imem_req), 32'd0);
        chk("t2_idle_cnt", 32'(count), 32'd4);
        out_ready = 1'b1;
        tick();
        chk("t2_pop4", out_pc, 32'h4);
        chk("t2_cnt3", 32'(count), 32'd3);
        chk("t2_resume", imem_addr, 32'h10);
        chk("t2_req_on", 32'(imem_req), 32'd1);
        tick();
        chk("t2_pop8", out_pc, 32'h8);
        tick();
        chk("t2_popC", out_pc, 32'hC);
        tick();
        chk("t2_pop10", out_pc, 32'h10);
        chk("t2_ins10", out_instr, 32'h10 ^ K);

        // 3: flush with 3 queued words and a simultaneous pop
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b0;
        reset     = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("t3_cnt3", 32'(count), 32'd3);
        flush     = 1'b1;
        flush_pc  = 32'h103;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_cnt0", 32'(count), 32'd0);
        chk("t3_valid0", 32'(out_valid), 32'd0);
        chk("t3_req0", 32'(imem_req), 32'd0);
        tick();
        chk("t3_req1", 32'(imem_req), 32'd1);
        chk("t3_addr", imem_addr, 32'h100);
        tick();
        chk("t3_outpc", out_pc, 32'h100);
        chk("t3_outv", 32'(out_valid), 32'd1);

        // 4: flush while a request is stalled
        do_reset();
        imem_ack  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        flush_pc  = 32'h20;
        reset     = 1'b0;
        tick();
        flush = 1'b0;
        chk("t4_idle", 32'(imem_req), 32'd0);
        tick();
        chk("t4_addr20", imem_addr, 32'h20);
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        chk("t4_hold_req", 32'(imem_req), 32'd1);
        chk("t4_hold_addr", imem_addr, 32'h20);
        flush    = 1'b1;
        flush_pc = 32'h80;
        tick();
        flush = 1'b0;
        chk("t4_drop_req", 32'(imem_req), 32'd1);
        chk("t4_drop_addr", imem_addr, 32'h20);
        tick();
        chk("t4_drop_addr2", imem_addr, 32'h20);
        imem_ack = 1'b1;
        tick();
        chk("t4_req_off", 32'(imem_req), 32'd0);
        chk("t4_no_out", 32'(out_valid), 32'd0);
        chk("t4_cnt0", 32'(count), 32'd0);
        tick();
        chk("t4_addr80", imem_addr, 32'h80);
        tick();
        chk("t4_outv", 32'(out_valid), 32'd1);
        chk("t4_outpc", out_pc, 32'h80);

        // 5: address wrap
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b1;
        flush_pc  = 32'hFFFF_FFF8;
        reset     = 1'b0;
        tick();
        flush = 1'b0;
        tick();
        chk("t5_F8", imem_addr, 32'hFFFF_FFF8);
        tick();
        chk("t5_FC", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t5_wrap", imem_addr, 32'h0);
        chk("t5_pcFC", out_pc, 32'hFFFF_FFFC);
        tick();
        chk("t5_pc0", out_pc, 32'h0);

        // 6: asynchronous reset mid-request
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b0;
        reset     = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_cnt2", 32'(count), 32'd2);
        imem_ack = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_req0", 32'(imem_req), 32'd0);
        chk("t6_valid0", 32'(out_valid), 32'd0);
        chk("t6_cnt0", 32'(count), 32'd0);
        chk("t6_addr0", imem_addr, 32'h0);
        tick();
        reset    = 1'b0;
        imem_ack = 1'b1;
        tick();
        chk("t6_req1", 32'(imem_req), 32'd1);
        chk("t6_raddr", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
